// File: rtl/rr_arb_mux.sv
// Registered N:1 round-robin arbitrating multiplexer: fair selection among enabled,
// valid input channels into a single output register that carries the word and its source index.
module rr_arb_mux #(
    parameter  int N     = 8,
    parameter  int WIDTH = 3,
    localparam int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N-1:0]       ch_en,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    // Handshake: a word moves on a rising edge exactly when valid and ready are both
    // high on that side. in_ready may follow in_valid combinationally; producers must not
    // make in_valid depend on in_ready. The output word stays stable while out_valid=1
    // and out_ready=0.

    logic [N-1:0]     req;
    logic             any_req;
    logic             load;
    logic [SW-1:0]    last;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] ch_word [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_word[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign req     = in_valid & ch_en;
    assign any_req = |req;
    assign load    = !out_valid || out_ready;

    // Scan starts just after the last granted channel and ends on it, so a lone
    // request from the last winner is granted again.
    always_comb begin : arb
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = SW'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load && any_req) begin
            in_ready = N'(1) << grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            last      <= SW'(N - 1);
        end else if (load) begin
            if (any_req) begin
                out_data  <= ch_word[grant];
                out_sel   <= grant;
                out_valid <= 1'b1;
                last      <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=8, WIDTH=3): rotation, backpressure,
// sparse requests, masking, drain, last-winner re-grant, async reset and data path.
module tb_rr_arb_mux;

    localparam int N     = 8;
    localparam int WIDTH = 3;
    localparam int SW    = 3;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N-1:0]       ch_en;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;

    int tests;
    int fails;

    rr_arb_mux #(.N(N), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ch_en    (ch_en),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_identity_data();
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 3'(i);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++;
        if (out_data !== 3'd0) begin fails++; $display("FAIL reset_data got %0d want 0", out_data); end
        tests++;
        if (out_sel !== 3'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", out_sel); end
        tests++;
        if (in_ready !== 8'h00) begin fails++; $display("FAIL reset_in_ready got %h want 00", in_ready); end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 8'h01) begin fails++; $display("FAIL release_in_ready got %h want 01", in_ready); end
    endtask

    // All channels requesting: grants 0..7,0 on consecutive cycles.
    task automatic test_rotation();
        logic [N-1:0] exp_rdy;
        for (int k = 0; k < 9; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1) begin fails++; $display("FAIL rot_valid[%0d] got %b want 1", k, out_valid); end
            tests++;
            if (out_sel !== 3'(k % 8)) begin fails++; $display("FAIL rot_sel[%0d] got %0d want %0d", k, out_sel, k % 8); end
            tests++;
            if (out_data !== 3'(k % 8)) begin fails++; $display("FAIL rot_data[%0d] got %0d want %0d", k, out_data, k % 8); end
            exp_rdy = 8'h01 << ((k + 1) % 8);
            tests++;
            if (in_ready !== exp_rdy) begin fails++; $display("FAIL rot_in_ready[%0d] got %h want %h", k, in_ready, exp_rdy); end
        end
    endtask

    // Last grant is 0; advance to channel 5, then stall three cycles.
    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (out_sel !== 3'd5 || out_data !== 3'b101) begin
            fails++; $display("FAIL bp_setup got sel %0d data %b want sel 5 data 101", out_sel, out_data);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (in_ready !== 8'h00) begin fails++; $display("FAIL bp_in_ready[%0d] got %h want 00", k, in_ready); end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== 3'b101) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v%b sel %0d data %b want v1 sel 5 data 101", k, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 8'h40) begin fails++; $display("FAIL bp_resume_in_ready got %h want 40", in_ready); end
        tick();
        tests++;
        if (out_sel !== 3'd6 || out_data !== 3'd6) begin fails++; $display("FAIL bp_resume got sel %0d data %0d want 6", out_sel, out_data); end
    endtask

    // Channel 2 alone sets last=2, then channels 2 and 7 alternate starting with 7.
    task automatic test_sparse();
        logic [SW-1:0] exp_sel [4];
        logic [N-1:0]  exp_rdy [4];
        exp_sel = '{3'd7, 3'd2, 3'd7, 3'd2};
        exp_rdy = '{8'h80, 8'h04, 8'h80, 8'h04};
        in_valid = 8'h04;
        tick();
        tests++;
        if (out_sel !== 3'd2) begin fails++; $display("FAIL sparse_setup got sel %0d want 2", out_sel); end
        in_valid = 8'h84;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if (in_ready !== exp_rdy[k]) begin fails++; $display("FAIL sparse_in_ready[%0d] got %h want %h", k, in_ready, exp_rdy[k]); end
            tick();
            tests++;
            if (out_sel !== exp_sel[k]) begin fails++; $display("FAIL sparse_sel[%0d] got %0d want %0d", k, out_sel, exp_sel[k]); end
        end
    endtask

    // Grant channel 7 first so the masked rotation starts at channel 1.
    task automatic test_mask();
        logic [SW-1:0] exp_sel [5];
        exp_sel = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1};
        in_valid = 8'h80;
        tick();
        in_valid = 8'hFF;
        ch_en    = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if ((in_ready & 8'h55) !== 8'h00 || in_ready !== (8'h01 << exp_sel[k])) begin
                fails++; $display("FAIL mask_in_ready[%0d] got %h want %h", k, in_ready, 8'h01 << exp_sel[k]);
            end
            tick();
            tests++;
            if (out_sel !== exp_sel[k] || out_data !== exp_sel[k]) begin
                fails++; $display("FAIL mask_sel[%0d] got sel %0d data %0d want %0d", k, out_sel, out_data, exp_sel[k]);
            end
        end
        ch_en = 8'hFF;
    endtask

    task automatic test_idle_drain();
        in_valid = 8'h10;
        tick();
        in_valid = 8'h00;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 3'b100 || out_sel !== 3'd4) begin
            fails++; $display("FAIL drain_word got v%b sel %0d data %b want v1 sel 4 data 100", out_valid, out_sel, out_data);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0 || out_data !== 3'b100) begin
                fails++; $display("FAIL drain_idle[%0d] got v%b data %b want v0 data 100", k, out_valid, out_data);
            end
        end
    endtask

    // Channel 4 is the last winner and the only requester: it wins again.
    task automatic test_single_last();
        in_valid = 8'h10;
        #1;
        tests++;
        if (in_ready !== 8'h10) begin fails++; $display("FAIL single_in_ready got %h want 10", in_ready); end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_sel !== 3'd4) begin fails++; $display("FAIL single_sel got v%b sel %0d want v1 sel 4", out_valid, out_sel); end
        in_valid = 8'h00;
    endtask

    task automatic test_async_reset();
        in_valid = 8'hFF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_sel !== 3'd0 || out_data !== 3'd0) begin
            fails++; $display("FAIL async_clear got v%b sel %0d data %0d want all 0", out_valid, out_sel, out_data);
        end
        tests++;
        if (in_ready !== 8'h00) begin fails++; $display("FAIL async_in_ready got %h want 00", in_ready); end
        @(negedge clk);
        in_valid = 8'b0011_0100;
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 8'h04) begin fails++; $display("FAIL async_first_ready got %h want 04", in_ready); end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 3'd2) begin
            fails++; $display("FAIL async_first_grant got v%b sel %0d data %0d want v1 sel 2 data 2", out_valid, out_sel, out_data);
        end
    endtask

    // Reversed channel data (ch i carries 7-i) so data and index are independent.
    task automatic test_data_path();
        logic [SW-1:0]    exp_sel [4];
        logic [WIDTH-1:0] exp_dat [4];
        exp_sel = '{3'd3, 3'd4, 3'd5, 3'd6};
        exp_dat = '{3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 3'(7 - i);
        in_valid = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (out_sel !== exp_sel[k] || out_data !== exp_dat[k]) begin
                fails++; $display("FAIL data_path[%0d] got sel %0d data %0d want sel %0d data %0d", k, out_sel, out_data, exp_sel[k], exp_dat[k]);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 8'hFF;
        ch_en     = 8'hFF;
        out_ready = 1'b1;
        in_data   = '0;
        set_identity_data();
        test_reset();
        test_rotation();
        test_backpressure();
        test_sparse();
        test_mask();
        test_idle_drain();
        test_single_last();
        test_async_reset();
        test_data_path();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
